// File: rtl/pu_tile_mac_if.sv
// Handshake and data bundle between the control unit and the 4x4 tile MAC.
// The slave modport is the processing unit; the master modport is the
// control unit that sequences the k-loop over tiles.
interface pu_tile_mac_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic                     i_PU_Start;
    logic                     i_Clear_Acc;
    logic [16*DATA_W-1:0]     i_A_Tile;
    logic [16*DATA_W-1:0]     i_B_Tile;
    logic [3:0]               i_Result_Index;
    logic                     i_Partial_Output_Ack;
    logic                     o_Busy;
    logic                     o_Partial_Output_Ready;
    logic [ACC_W-1:0]         o_Result_Data;
    logic                     o_Overflow;

    modport slave (
        input  i_PU_Start,
        input  i_Clear_Acc,
        input  i_A_Tile,
        input  i_B_Tile,
        input  i_Result_Index,
        input  i_Partial_Output_Ack,
        output o_Busy,
        output o_Partial_Output_Ready,
        output o_Result_Data,
        output o_Overflow
    );

    modport master (
        output i_PU_Start,
        output i_Clear_Acc,
        output i_A_Tile,
        output i_B_Tile,
        output i_Result_Index,
        output i_Partial_Output_Ack,
        input  o_Busy,
        input  o_Partial_Output_Ready,
        input  o_Result_Data,
        input  o_Overflow
    );
endinterface

// File: rtl/pu_tile_mac.sv
// 4x4 tile multiply-accumulate: C += A*B, one row-step of four MACs per cycle.
// Tiles are latched on start; results stay frozen in DONE until acknowledged
// and persist afterwards so the next tile can continue the accumulation.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start; accumulators hold last results
// ST_COMPUTE | 16 steps, step = {r,k}, four MACs C[r][c] += A[r][k]*B[k][c]
// ST_DONE    | results ready and frozen until ack
module pu_tile_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    pu_tile_mac_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                   state;
    logic [3:0]               step;
    logic signed [DATA_W-1:0] a_mat [16];
    logic signed [DATA_W-1:0] b_mat [16];
    logic signed [ACC_W-1:0]  acc   [16];
    logic                     ovf;
    logic                     busy;
    logic                     ready;

    logic [1:0]                 row;
    logic [1:0]                 kk;
    logic signed [DATA_W-1:0]   a_el;
    logic [3:0]                 acc_idx [4];
    logic signed [DATA_W-1:0]   b_el    [4];
    logic signed [2*DATA_W-1:0] prod    [4];
    logic signed [ACC_W-1:0]    addend  [4];
    logic signed [ACC_W-1:0]    sum     [4];
    logic [3:0]                 add_ovf;

    assign row = step[3:2];
    assign kk  = step[1:0];

    // Four parallel MACs for the current {r,k} step with signed-overflow detect.
    always_comb begin
        a_el    = a_mat[step];
        add_ovf = '0;
        for (int c = 0; c < 4; c++) begin
            acc_idx[c] = {row, 2'(c)};
            b_el[c]    = b_mat[{kk, 2'(c)}];
            prod[c]    = a_el * b_el[c];
            addend[c]  = ACC_W'(prod[c]);
            sum[c]     = acc[acc_idx[c]] + addend[c];
            // Same-sign operands producing an opposite-sign sum means wrap.
            add_ovf[c] = (acc[acc_idx[c]][ACC_W-1] == addend[c][ACC_W-1]) &&
                         (sum[c][ACC_W-1] != acc[acc_idx[c]][ACC_W-1]);
        end
    end

    // Sequencer: tile latch, step counter, accumulators and registered status.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state <= ST_IDLE;
            step  <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                a_mat[i] <= '0;
                b_mat[i] <= '0;
                acc[i]   <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_PU_Start) begin
                        for (int i = 0; i < 16; i++) begin
                            a_mat[i] <= bus.i_A_Tile[DATA_W*i +: DATA_W];
                            b_mat[i] <= bus.i_B_Tile[DATA_W*i +: DATA_W];
                        end
                        if (bus.i_Clear_Acc) begin
                            ovf <= 1'b0;
                            for (int i = 0; i < 16; i++) begin
                                acc[i] <= '0;
                            end
                        end
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    for (int c = 0; c < 4; c++) begin
                        acc[acc_idx[c]] <= sum[c];
                    end
                    if (|add_ovf) begin
                        ovf <= 1'b1;
                    end
                    step <= step + 4'd1;
                    if (step == 4'd15) begin
                        ready <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A start in the same cycle as the ack is dropped on purpose.
                    if (bus.i_Partial_Output_Ack) begin
                        busy  <= 1'b0;
                        ready <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    ready <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_Busy                 = busy;
    assign bus.o_Partial_Output_Ready = ready;
    assign bus.o_Overflow             = ovf;
    assign bus.o_Result_Data          = acc[bus.i_Result_Index];

endmodule
